// File: rtl/mycpu_pkg.sv
// Shared I/O controller types: FSM state encoding, default widths, error read pattern.
// No logic of its own.
package mycpu_pkg;

    localparam int IO_DATA_WIDTH     = 16;
    localparam int IO_ADDR_WIDTH     = 8;
    localparam int IO_TIMEOUT_CYCLES = 32;
    localparam int IO_CNT_WIDTH      = 8;

    // Returned on a read that was aborted; sliced to the bus data width by users.
    localparam logic [63:0] IO_ERR_RDATA = '1;

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_ACCESS,
        IO_DONE,
        IO_ERR
    } io_ctrl_state_t;

endpackage

// File: rtl/io_timeout_cnt.sv
// Clearable saturating cycle counter; expired is high while count equals LIMIT-1.
// Latency: count updates one edge after inc; expired is combinational from count.
// Backpressure: none, the counter simply holds at its maximum value.
module io_timeout_cnt #(
    parameter int LIMIT = 32,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/io_bus_ctrl.sv
// Sequences CPU IOR/IOW onto a req/ack I/O bus; IO_TIMEOUT_EN adds abort-on-no-ack with sticky error.
// Latency: 2 stall cycles with ack in the first ACCESS cycle, +1 per ack wait cycle.
// Backpressure: the CPU is stalled for as long as the bus withholds io_ack_in.
module io_bus_ctrl
    import mycpu_pkg::*;
#(
    parameter int DATA_WIDTH     = IO_DATA_WIDTH,
    parameter int ADDR_WIDTH     = IO_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = IO_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_iom_in,
    input  logic                  cpu_wen_in,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_in,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_in,
    output logic [DATA_WIDTH-1:0] cpu_rdata_out,
    output logic                  cpu_stall_out,
    output logic                  cpu_err_out,
    input  logic                  err_clr_in,
    output logic                  io_req_out,
    output logic                  io_we_out,
    output logic [ADDR_WIDTH-1:0] io_addr_out,
    output logic [DATA_WIDTH-1:0] io_wdata_out,
    input  logic [DATA_WIDTH-1:0] io_rdata_in,
    input  logic                  io_ack_in
);

    io_ctrl_state_t state, state_nxt;
    logic           stall_c;
    logic           to_expired;
    logic           err_set;

`ifdef IO_TIMEOUT_EN
    logic err_q;

    // Held clear while idle so every ACCESS starts counting from zero.
    io_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (IO_CNT_WIDTH)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IO_IDLE),
        .inc     ((state == IO_ACCESS) && !io_ack_in),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_set | (err_q & ~err_clr_in);
        end
    end

    assign cpu_err_out = err_q;
`else
    logic unused_cfg;

    assign to_expired  = 1'b0;
    assign cpu_err_out = 1'b0;
    assign unused_cfg  = err_clr_in | (TIMEOUT_CYCLES == 0);
`endif

    // Ack has priority over an expiring timeout.
    assign err_set = (state == IO_ACCESS) && !io_ack_in && to_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IO_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IO_IDLE: begin
                if (cpu_iom_in) begin
                    stall_c   = 1'b1;
                    state_nxt = IO_ACCESS;
                end
            end
            IO_ACCESS: begin
                stall_c = 1'b1;
                if (io_ack_in) begin
                    state_nxt = IO_DONE;
                end else if (to_expired) begin
                    state_nxt = IO_ERR;
                end
            end
            // The CU has already moved on, so any iom seen here is stale.
            IO_DONE:  state_nxt = IO_IDLE;
            IO_ERR:   state_nxt = IO_IDLE;
            default:  state_nxt = IO_IDLE;
        endcase
    end

    assign cpu_stall_out = rst ? 1'b0 : stall_c;
    assign io_req_out    = (state == IO_ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            io_we_out     <= 1'b0;
            io_addr_out   <= '0;
            io_wdata_out  <= '0;
            cpu_rdata_out <= '0;
        end else begin
            if ((state == IO_IDLE) && cpu_iom_in) begin
                io_we_out    <= ~cpu_wen_in;
                io_addr_out  <= cpu_addr_in;
                io_wdata_out <= cpu_wdata_in;
            end
            if ((state == IO_ACCESS) && io_ack_in && !io_we_out) begin
                cpu_rdata_out <= io_rdata_in;
            end else if (err_set && !io_we_out) begin
                cpu_rdata_out <= IO_ERR_RDATA[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Randomized transaction-level bench for io_bus_ctrl against a per-transaction reference model.
module tb_io_bus_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int TO = 4;
    localparam int BOUND = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_iom_in;
    logic          cpu_wen_in;
    logic [AW-1:0] cpu_addr_in;
    logic [DW-1:0] cpu_wdata_in;
    logic [DW-1:0] cpu_rdata_out;
    logic          cpu_stall_out;
    logic          cpu_err_out;
    logic          err_clr_in;
    logic          io_req_out;
    logic          io_we_out;
    logic [AW-1:0] io_addr_out;
    logic [DW-1:0] io_wdata_out;
    logic [DW-1:0] io_rdata_in;
    logic          io_ack_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit aborted = 1'b0;

    logic [DW-1:0] exp_rdata;
    logic          exp_err;

    io_bus_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_iom_in    (cpu_iom_in),
        .cpu_wen_in    (cpu_wen_in),
        .cpu_addr_in   (cpu_addr_in),
        .cpu_wdata_in  (cpu_wdata_in),
        .cpu_rdata_out (cpu_rdata_out),
        .cpu_stall_out (cpu_stall_out),
        .cpu_err_out   (cpu_err_out),
        .err_clr_in    (err_clr_in),
        .io_req_out    (io_req_out),
        .io_we_out     (io_we_out),
        .io_addr_out   (io_addr_out),
        .io_wdata_out  (io_wdata_out),
        .io_rdata_in   (io_rdata_in),
        .io_ack_in     (io_ack_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU I/O instruction; the bus acks in ACCESS cycle d (0 = first cycle).
    task automatic run_txn(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int d, input bit clr);
        int            k;
        int            stalls;
        int            last;
        bit            tmo;
        logic [DW-1:0] ack_dat;
        logic [DW-1:0] r;
`ifdef IO_TIMEOUT_EN
        tmo = (d >= TO);
`else
        tmo = 1'b0;
`endif
        last    = tmo ? TO - 1 : d;
        ack_dat = '0;

        @(negedge clk);
        cpu_iom_in   = 1'b1;
        cpu_wen_in   = rd;
        cpu_addr_in  = a;
        cpu_wdata_in = wd;
        io_ack_in    = 1'($urandom);
        io_rdata_in  = DW'($urandom);
        #1;
        chk("idle_stall", cpu_stall_out, 1'b1);
        stalls = 1;
        k = 0;
        forever begin
            @(negedge clk);
            if (!cpu_stall_out) break;
            stalls++;
            chk("acc_req", io_req_out, 1'b1);
            chk("acc_we", io_we_out, !rd);
            chk("acc_addr", io_addr_out, a);
            chk("acc_wdata", io_wdata_out, wd);
            r           = DW'($urandom);
            io_rdata_in = r;
            io_ack_in   = (k == d);
            if (k == d) ack_dat = r;
            err_clr_in  = clr && (k == last);
            k++;
            if (k > BOUND) begin
                chk("access_bound", 32'(k), 32'(last + 1));
                aborted = 1'b1;
                break;
            end
        end
        cpu_iom_in = 1'b0;
        err_clr_in = 1'b0;
        if (aborted) return;

        if (rd) exp_rdata = tmo ? {DW{1'b1}} : ack_dat;
`ifdef IO_TIMEOUT_EN
        exp_err = tmo ? 1'b1 : (exp_err & ~clr);
`endif
        chk("stall_cycles", 32'(stalls), 32'(last + 2));
        chk("done_req", io_req_out, 1'b0);
        chk("done_rdata", cpu_rdata_out, exp_rdata);
        chk("done_err", cpu_err_out, exp_err);

        io_ack_in   = 1'($urandom);
        io_rdata_in = DW'($urandom);
        @(negedge clk);
        chk("idle_stall0", cpu_stall_out, 1'b0);
        chk("idle_req", io_req_out, 1'b0);
        chk("idle_rdata", cpu_rdata_out, exp_rdata);
        io_ack_in = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        cpu_iom_in   = 1'b1;
        cpu_wen_in   = 1'b1;
        cpu_addr_in  = '0;
        cpu_wdata_in = '0;
        err_clr_in   = 1'b0;
        io_rdata_in  = '0;
        io_ack_in    = 1'b0;
        exp_rdata    = '0;
        exp_err      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", cpu_stall_out, 1'b0);
        chk("rst_req", io_req_out, 1'b0);
        chk("rst_we", io_we_out, 1'b0);
        chk("rst_addr", io_addr_out, '0);
        chk("rst_wdata", io_wdata_out, '0);
        chk("rst_rdata", cpu_rdata_out, '0);
        chk("rst_err", cpu_err_out, 1'b0);
        cpu_iom_in = 1'b0;
        rst        = 1'b0;

        run_txn(1'b1, 8'h12, 16'h0000, 0, 1'b0);
        chk("read_beef", cpu_rdata_out, exp_rdata);
        run_txn(1'b0, 8'h05, 16'h00A5, 3, 1'b0);

        // Reset during ACCESS with an ack pending: nothing may be captured.
        @(negedge clk);
        cpu_iom_in = 1'b1;
        cpu_wen_in = 1'b1;
        cpu_addr_in = 8'h77;
        repeat (2) @(negedge clk);
        rst         = 1'b1;
        io_ack_in   = 1'b1;
        io_rdata_in = 16'h1234;
        @(negedge clk);
        chk("mid_rst_req", io_req_out, 1'b0);
        chk("mid_rst_stall", cpu_stall_out, 1'b0);
        chk("mid_rst_rdata", cpu_rdata_out, '0);
        chk("mid_rst_addr", io_addr_out, '0);
        chk("mid_rst_we", io_we_out, 1'b0);
        rst        = 1'b0;
        io_ack_in  = 1'b0;
        cpu_iom_in = 1'b0;
        exp_rdata  = '0;
        exp_err    = 1'b0;

        for (int i = 0; i < 40 && !aborted; i++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom),
                    int'($urandom_range(0, TO + 2)), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                io_ack_in   = 1'($urandom);
                io_rdata_in = DW'($urandom);
            end
            io_ack_in = 1'b0;
        end

`ifdef IO_TIMEOUT_EN
        if (!aborted) begin
            run_txn(1'b1, 8'h33, 16'h0, TO + 1, 1'b0);
            chk("tmo_rdata", cpu_rdata_out, 16'hFFFF);
            chk("tmo_err", cpu_err_out, 1'b1);
            @(negedge clk);
            err_clr_in = 1'b1;
            @(negedge clk);
            err_clr_in = 1'b0;
            exp_err    = 1'b0;
            chk("err_clr", cpu_err_out, 1'b0);
            run_txn(1'b1, 8'h34, 16'h0, TO + 3, 1'b1);
            chk("set_wins", cpu_err_out, 1'b1);
            run_txn(1'b1, 8'h35, 16'h0, TO - 1, 1'b0);
            chk("ack_wins_rdata", cpu_rdata_out, exp_rdata);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Sequences CPU I/O instructions (IOR/IOW) onto an external request/acknowledge I/O bus.
- Sits between the CPU datapath/control-unit I/O signals (iom, wen, address, data) and the peripheral bus.
- Stalls the CPU while a bus transaction is outstanding and returns read data.
- Optionally aborts transactions that are never acknowledged, and flags the error.

Parameters:
- DATA_WIDTH, 16, width of CPU and bus data words
- ADDR_WIDTH, 8, width of I/O address
- TIMEOUT_CYCLES, 32, number of ACCESS-state cycles without ack before abort (only with IO_TIMEOUT_EN); legal range 1..255

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_iom_in  in  1  CPU requests an I/O access this cycle
- cpu_wen_in  in  1  CPU write-enable; 0 = I/O write (IOW), 1 = I/O read (IOR)
- cpu_addr_in  in  ADDR_WIDTH  I/O address
- cpu_wdata_in  in  DATA_WIDTH  write data
- cpu_rdata_out  out  DATA_WIDTH  read data returned to datapath
- cpu_stall_out  out  1  holds CU in current state while high
- cpu_err_out  out  1  sticky bus error flag
- err_clr_in  in  1  clears cpu_err_out
- io_req_out  out  1  bus request
- io_we_out  out  1  bus write strobe (1 = write)
- io_addr_out  out  ADDR_WIDTH  bus address
- io_wdata_out  out  DATA_WIDTH  bus write data
- io_rdata_in  in  DATA_WIDTH  bus read data, valid with ack
- io_ack_in  in  1  bus acknowledge

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; io_req_out=0; io_we_out=0; io_addr_out=0; io_wdata_out=0; cpu_rdata_out=0; cpu_err_out=0; timeout count=0.
- cpu_stall_out is combinational from state and inputs. It is 0 during reset.
- State IDLE:
  - If cpu_iom_in=1: cpu_stall_out=1 in the same cycle.
  - At the clock edge, capture addr, wdata and we = ~cpu_wen_in into the io_* registers, then go to ACCESS.
  - Otherwise stall=0 and stay in IDLE.
- State ACCESS:
  - io_req_out=1 and stall=1.
  - io_* outputs are held stable until ack.
  - If io_ack_in=1 is sampled: capture io_rdata_in into cpu_rdata_out on reads only (writes leave cpu_rdata_out unchanged). Go to DONE; io_req_out is 0 from the next cycle.
- State DONE:
  - stall=0 and io_req_out=0; cpu_rdata_out is valid.
  - cpu_iom_in is ignored. Next state is always IDLE, because the CU has already advanced to INF.
- Latency: ack in the first ACCESS cycle gives 2 stall cycles; data is usable in the 3rd cycle. Each extra ack wait cycle adds one stall cycle.
- Ack rules: io_ack_in in IDLE or DONE is ignored. Ack and timeout expiring in the same cycle: ack wins.
- Error flag:
  - err_clr_in clears cpu_err_out at the next edge.
  - Simultaneous set and clear: set wins.
- Reset mid-transaction: io_req_out drops at the next edge, the transaction is discarded, and no data is written to cpu_rdata_out.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- When defined:
  - A counter increments every ACCESS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack, go to state ERR at the next edge.
  - ERR: io_req_out=0, stall=0, cpu_err_out set (sticky). On reads, cpu_rdata_out = all ones. Next state is IDLE.
  - The counter clears on entering ACCESS.
- When undefined:
  - No counter and no ERR state; ACCESS waits indefinitely.
  - cpu_err_out is tied to 0 and err_clr_in is unused.

Decomposition:
- Shared package mycpu_pkg holds:
  - io_ctrl_state_t enum {IO_IDLE, IO_ACCESS, IO_DONE, IO_ERR}
  - IO_ERR_RDATA constant (all ones)
  - default width localparams
- Natural sub-module: io_timeout_cnt, a clearable saturating counter with an expiry output. Instantiated only under IO_TIMEOUT_EN.

Test Plan:
- Read with immediate ack:
  - Stimulus: iom=1, wen=1, addr=0x12; ack=1 with rdata=0xBEEF in the first ACCESS cycle.
  - Required: stall high for 2 cycles; io_we_out=0; cpu_rdata_out=0xBEEF in DONE; err stays 0.
- Write with 3-cycle ack delay:
  - Stimulus: iom=1, wen=0, addr=0x05, wdata=0x00A5.
  - Required: io_req/io_we=1 and addr/wdata stable for 4 ACCESS cycles; stall for 5 cycles; cpu_rdata_out unchanged.
- Spurious ack:
  - Stimulus: ack=1 while in IDLE; ack held high through DONE.
  - Required: no state change, no rdata capture, no second request.
- Timeout (IO_TIMEOUT_EN, TIMEOUT_CYCLES=4), no ack on a read:
  - Required: ERR entered after 4 ACCESS cycles; rdata=0xFFFF; err=1 (sticky).
  - Then: err_clr_in pulse clears it; err_clr_in and a new timeout in the same cycle leave err=1.
- Reset mid-ACCESS:
  - Stimulus: rst=1 for 1 cycle during ACCESS.
  - Required: io_req_out=0 and all outputs at reset values at the next edge; a following read completes normally.
- Ack and timeout expiry in the same cycle:
  - Required: DONE is taken, rdata = io_rdata_in, err stays 0.
